sobel_pipe_param: RTL

- Parametrised successor of the fixed 8-bit luma/blur video top.
- Accepts a streaming RGB pixel bus with dv/hs/vs, converts to luma and buffers two lines internally.
- Computes a 3x3 Sobel gradient magnitude and emits one of four frame-selectable output modes.
- Output syncs are delayed to match the data pipeline exactly.
- Sits between the video input decoder and the display/encoder output stage.

---
 rtl/sobel_pipe_param.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sobel_pipe_param.sv
// sobel_pipe_param: RGB stream -> luma -> 3x3 Sobel magnitude, 4-cycle pipeline.
// Output mode (passthrough / gray / magnitude / threshold) is latched per frame.
// Optional macro SOBEL_OVERLAY_EN: mode 3 draws red edges over the source image.
module sobel_pipe_param #(
  parameter int COLORDEPTH = 8,
  parameter int MAX_WIDTH  = 1920
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLORDEPTH-1:0] red_i,
  input  logic [COLORDEPTH-1:0] green_i,
  input  logic [COLORDEPTH-1:0] blue_i,
  input  logic                  dv_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  input  logic [1:0]            mode_i,
  input  logic [COLORDEPTH-1:0] thresh_i,
  output logic [COLORDEPTH-1:0] red_o,
  output logic [COLORDEPTH-1:0] green_o,
  output logic [COLORDEPTH-1:0] blue_o,
  output logic                  dv_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  overflow_o
);
  localparam int CD = COLORDEPTH;
  localparam int AW = $clog2(MAX_WIDTH);
  localparam int CW = $clog2(MAX_WIDTH + 1);  // col_cnt must be able to hold MAX_WIDTH
  localparam int GW = CD + 3;

  typedef struct packed {
    logic [CD-1:0] r;
    logic [CD-1:0] g;
    logic [CD-1:0] b;
  } rgb_t;

  // syncs {vs,hs,dv} per stage; stage 4 drives the outputs
  logic [4:1][2:0] sp;
  rgb_t s1_px, s2_px, s3_px, out_q, out_c;
  logic [CD-1:0] s1_y, s2_y, s3_y;
  logic [CD+9:0] ysum;
  logic [CW-1:0] col_cnt, col_addr;
  logic [1:0]    line_cnt, mode_r;
  logic          dv_rise1, dv_fall1, vs_rise1, ovf_pix, wr_en;
  logic [AW-1:0] idx;
  logic [CD-1:0] lb0 [MAX_WIDTH];
  logic [CD-1:0] lb1 [MAX_WIDTH];
  logic [CD-1:0] rd0, rd1;
  logic [2:0][2:0][CD-1:0] w;  // w[row][col], row 2 / col 2 = newest
  logic          s2_wv, s3_wv;
  logic signed [GW-1:0] gx_c, gy_c, gx, gy;
  logic [GW-1:0] ax, ay;
  logic [GW:0]   mag_sum;
  logic [CD-1:0] mag, mag_m;
  logic          edge_hit;
  logic          unused_ok;

  assign ysum = {10'b0, red_i}   * (CD+10)'(77)
              + {10'b0, green_i} * (CD+10)'(150)
              + {10'b0, blue_i}  * (CD+10)'(29);
  assign unused_ok = ^ysum[CD+9:CD+8];

  // sync delay line and stage-1 data (luma)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp    <= '0;
      s1_px <= '0;
      s1_y  <= '0;
    end else begin
      sp[4:2] <= sp[3:1];
      sp[1]   <= {vs_i, hs_i, dv_i};
      s1_px   <= '{r: red_i, g: green_i, b: blue_i};
      s1_y    <= ysum[CD+7:8];
    end
  end

  // edges seen at stage 1 against the previous stage-1 sample
  assign dv_rise1 = sp[1][0] & ~sp[2][0];
  assign dv_fall1 = ~sp[1][0] & sp[2][0];
  assign vs_rise1 = sp[1][2] & ~sp[2][2];
  assign col_addr = dv_rise1 ? '0 : col_cnt;
  assign ovf_pix  = sp[1][0] && (col_addr == CW'(MAX_WIDTH));
  assign wr_en    = sp[1][0] && !ovf_pix;
  assign idx      = col_addr[AW-1:0];
  assign rd0      = lb0[idx];
  assign rd1      = lb1[idx];

  // column / line counters, overflow flag, per-frame mode latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt    <= '0;
      line_cnt   <= '0;
      overflow_o <= 1'b0;
      mode_r     <= '0;
    end else begin
      if (sp[1][0]) col_cnt <= ovf_pix ? col_addr : col_addr + CW'(1);
      if (vs_rise1) line_cnt <= '0;
      else if (dv_fall1 && line_cnt != 2'd2) line_cnt <= line_cnt + 2'd1;
      if (vs_rise1) overflow_o <= 1'b0;
      else if (ovf_pix) overflow_o <= 1'b1;
      if (vs_i && !sp[1][2]) mode_r <= mode_i;
    end
  end

  // line buffers: not reset, stale contents are masked by line_cnt
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb0[idx] <= s1_y;
      lb1[idx] <= rd0;
    end
  end

  // stage 2: window shift on valid pixels, window-valid flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w     <= '0;
      s2_px <= '0;
      s2_y  <= '0;
      s2_wv <= 1'b0;
    end else begin
      if (wr_en) begin
        for (int r = 0; r < 3; r++) begin
          w[r][0] <= w[r][1];
          w[r][1] <= w[r][2];
        end
        w[0][2] <= rd1;
        w[1][2] <= rd0;
        w[2][2] <= s1_y;
      end
      s2_px <= s1_px;
      s2_y  <= s1_y;
      s2_wv <= wr_en && (line_cnt == 2'd2) && (col_addr >= CW'(2));
    end
  end

  function automatic logic signed [GW-1:0] ext(input logic [CD-1:0] v);
    return $signed({3'b000, v});
  endfunction

  assign gx_c = (ext(w[0][2]) + (ext(w[1][2]) <<< 1) + ext(w[2][2]))
              - (ext(w[0][0]) + (ext(w[1][0]) <<< 1) + ext(w[2][0]));
  assign gy_c = (ext(w[2][0]) + (ext(w[2][1]) <<< 1) + ext(w[2][2]))
              - (ext(w[0][0]) + (ext(w[0][1]) <<< 1) + ext(w[0][2]));

  // stage 3: gradients
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gx    <= '0;
      gy    <= '0;
      s3_px <= '0;
      s3_y  <= '0;
      s3_wv <= 1'b0;
    end else begin
      gx    <= gx_c;
      gy    <= gy_c;
      s3_px <= s2_px;
      s3_y  <= s2_y;
      s3_wv <= s2_wv;
    end
  end

  assign ax       = gx[GW-1] ? -gx : gx;
  assign ay       = gy[GW-1] ? -gy : gy;
  assign mag_sum  = {1'b0, ax} + {1'b0, ay};
  assign mag      = (|mag_sum[GW:CD]) ? '1 : mag_sum[CD-1:0];
  assign mag_m    = s3_wv ? mag : '0;
  assign edge_hit = mag_m > thresh_i;

  // stage 4 mux: mode select, blank when delayed dv is low
  always_comb begin
    out_c = '0;
    if (sp[3][0]) begin
      case (mode_r)
        2'd0: out_c = s3_px;
        2'd1: out_c = '{r: s3_y, g: s3_y, b: s3_y};
        2'd2: out_c = '{r: mag_m, g: mag_m, b: mag_m};
        default: begin
`ifdef SOBEL_OVERLAY_EN
          out_c = edge_hit ? '{r: '1, g: '0, b: '0} : s3_px;
`else
          out_c = edge_hit ? '1 : '0;
`endif
        end
      endcase
    end
  end

  // output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_q <= '0;
    else      out_q <= out_c;
  end

  assign red_o   = out_q.r;
  assign green_o = out_q.g;
  assign blue_o  = out_q.b;
  assign dv_o    = sp[4][0];
  assign hs_o    = sp[4][1];
  assign vs_o    = sp[4][2];
endmodule
